// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/step controller: state encodings and
// the width of the Mode output.
package cpu_ctrl_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } cpu_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes a raw board input, debounces it against the divider Tick and
// produces a one-cycle pulse on each rising edge of the debounced value.
module btn_debounce #(
  parameter int DebounceTicks = 4
) (
  input  logic Clkin,
  input  logic Rst,
  input  logic i_Tick,
  input  logic i_Raw,
  output logic o_Db,
  output logic o_Rise
);

  // The counter never needs to hold more than DebounceTicks-1.
  localparam int CNT_W = (DebounceTicks < 2) ? 1 : $clog2(DebounceTicks);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DebounceTicks - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic             r_db_d;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  // Two-flop synchronizer for the asynchronous raw input.
  always_ff @(posedge Clkin) begin
    if (Rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_Raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: only Tick cycles count; a matching sample restarts the run.
  always_ff @(posedge Clkin) begin
    if (Rst) begin
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else if (i_Tick) begin
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_db  <= ~r_db;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Registered rising-edge detect, one cycle after the debounced value rises.
  always_ff @(posedge Clkin) begin
    if (Rst) begin
      r_db_d <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_db_d <= r_db;
      r_rise <= r_db & ~r_db_d;
    end
  end

  assign o_Db   = r_db;
  assign o_Rise = r_rise;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller: gates the divider Tick into a single-cycle CPU
// clock-enable according to the Run switch, Step button and halt requests,
// and counts issued CPU cycles (saturating) for the display.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | CPU stopped; waiting for Run or a Step press
//  RUN   | free-run, one CpuEn per Tick
//  STEP  | one CpuEn on the next Tick, then back to IDLE
//  HALT  | stopped by HaltReq; Step press with Run off acknowledges
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DebounceTicks = 4,
  parameter int CycleCntW     = 16
) (
  input  logic                 Clkin,
  input  logic                 Rst,
  input  logic                 i_Tick,
  input  logic                 i_RunSw,
  input  logic                 i_StepBtn,
  input  logic                 i_HaltReq,
  output logic                 o_CpuEn,
  output logic [MODE_W-1:0]    o_Mode,
  output logic                 o_Halted,
  output logic [CycleCntW-1:0] o_CycleCount
);

  localparam logic [MODE_W-1:0] S_IDLE = ST_IDLE;
  localparam logic [MODE_W-1:0] S_RUN  = ST_RUN;
  localparam logic [MODE_W-1:0] S_STEP = ST_STEP;
  localparam logic [MODE_W-1:0] S_HALT = ST_HALT;

  logic                 w_run_db;
  logic                 w_step_pulse;
  logic [MODE_W-1:0]    w_state_nxt;
  logic                 w_cpu_en_nxt;
  logic [MODE_W-1:0]    r_state;
  logic                 r_cpu_en;
  logic                 r_halted;
  logic [CycleCntW-1:0] r_cycle_cnt;

  // Run only needs its level; Step only needs its rising edge.
  btn_debounce #(.DebounceTicks(DebounceTicks)) u_run_db (
    .Clkin  (Clkin),
    .Rst    (Rst),
    .i_Tick (i_Tick),
    .i_Raw  (i_RunSw),
    .o_Db   (w_run_db),
    .o_Rise ()
  );

  btn_debounce #(.DebounceTicks(DebounceTicks)) u_step_db (
    .Clkin  (Clkin),
    .Rst    (Rst),
    .i_Tick (i_Tick),
    .i_Raw  (i_StepBtn),
    .o_Db   (),
    .o_Rise (w_step_pulse)
  );

  // Next-state and enable decode; HaltReq outranks Run-off, which outranks Tick.
  always_comb begin
    w_state_nxt  = r_state;
    w_cpu_en_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_run_db)          w_state_nxt = S_RUN;
        else if (w_step_pulse) w_state_nxt = S_STEP;
      end
      S_RUN: begin
        if (i_HaltReq)      w_state_nxt  = S_HALT;
        else if (!w_run_db) w_state_nxt  = S_IDLE;
        else if (i_Tick)    w_cpu_en_nxt = 1'b1;
      end
      S_STEP: begin
        if (i_HaltReq) begin
          w_state_nxt = S_HALT;
        end else if (i_Tick) begin
          w_cpu_en_nxt = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      S_HALT: begin
        if (w_step_pulse && !w_run_db) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, CPU enable and Halted flag registers.
  always_ff @(posedge Clkin) begin
    if (Rst) begin
      r_state  <= S_IDLE;
      r_cpu_en <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cpu_en <= w_cpu_en_nxt;
      r_halted <= (w_state_nxt == S_HALT);
    end
  end

  // Saturating count of issued CPU cycles, updated the cycle after CpuEn.
  always_ff @(posedge Clkin) begin
    if (Rst) begin
      r_cycle_cnt <= '0;
    end else if (r_cpu_en && (r_cycle_cnt != '1)) begin
      r_cycle_cnt <= r_cycle_cnt + CycleCntW'(1);
    end
  end

  assign o_CpuEn      = r_cpu_en;
  assign o_Mode       = r_state;
  assign o_Halted     = r_halted;
  assign o_CycleCount = r_cycle_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl. Stimulus pushes the expected CycleCount
// seen at each CpuEn pulse into a queue; a monitor pops and checks on every
// CpuEn. A second instance with a 4-bit counter covers saturation.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        run_sw;
  logic        step_btn;
  logic        halt_req;
  logic        cpu_en, cpu_en_s;
  logic [1:0]  mode, mode_s;
  logic        halted, halted_s;
  logic [15:0] cnt;
  logic [3:0]  cnt_s;
  logic        tick_prev;

  int          errors = 0;
  int          checks = 0;
  int unsigned exp_q[$];
  int unsigned exp_cnt = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.DebounceTicks(4), .CycleCntW(16)) dut (
    .Clkin(clk), .Rst(rst), .i_Tick(tick), .i_RunSw(run_sw),
    .i_StepBtn(step_btn), .i_HaltReq(halt_req), .o_CpuEn(cpu_en),
    .o_Mode(mode), .o_Halted(halted), .o_CycleCount(cnt)
  );

  cpu_run_ctrl #(.DebounceTicks(4), .CycleCntW(4)) dut_sat (
    .Clkin(clk), .Rst(rst), .i_Tick(tick), .i_RunSw(run_sw),
    .i_StepBtn(step_btn), .i_HaltReq(halt_req), .o_CpuEn(cpu_en_s),
    .o_Mode(mode_s), .o_Halted(halted_s), .o_CycleCount(cnt_s)
  );

  always @(posedge clk) tick_prev <= tick;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every CpuEn must be expected, follow a Tick, and carry the
  // pre-increment count.
  always @(negedge clk) begin : monitor
    int unsigned v;
    if (rst === 1'b0 && cpu_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cpu_en: CpuEn=1 at %0t, expected 0", $time);
      end else begin
        v = exp_q.pop_front();
        check("cpu_en_count", cnt, v);
        check("cpu_en_after_tick", tick_prev, 1);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 10-cycle tick period; Tick (and optionally HaltReq) high for the first cycle.
  task automatic do_tick(input bit exp_pulse, input bit halt);
    tick     = 1'b1;
    halt_req = halt;
    if (exp_pulse) begin
      exp_q.push_back(exp_cnt);
      if (exp_cnt < 65535) exp_cnt++;
    end
    @(negedge clk);
    tick     = 1'b0;
    halt_req = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  task automatic ticks(input int n, input bit exp_pulse);
    for (int i = 0; i < n; i++) do_tick(exp_pulse, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    exp_cnt = 0;
    cycles(1);
  endtask

  // Press Step for 6 ticks and release; a CpuEn is due on the 5th tick if stepping.
  task automatic press_step(input bit exp_pulse);
    step_btn = 1'b1;
    cycles(3);
    ticks(4, 1'b0);
    do_tick(exp_pulse, 1'b0);
    do_tick(1'b0, 1'b0);
    step_btn = 1'b0;
    cycles(3);
    ticks(4, 1'b0);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; run_sw = 1'b0; step_btn = 1'b0; halt_req = 1'b0;
    cycles(3);
    check("reset_mode", mode, 0);
    check("reset_halted", halted, 0);
    check("reset_cpu_en", cpu_en, 0);
    check("reset_count", cnt, 0);
    rst = 1'b0;
    cycles(2);

    // Free-run: Run debounces after 4 ticks, then one CpuEn per Tick.
    run_sw = 1'b1;
    cycles(3);
    ticks(4, 1'b0);
    check("run_mode", mode, 1);
    ticks(10, 1'b1);
    check("run_count_10", cnt, 10);
    check("sat_count_10", cnt_s, 10);
    ticks(46, 1'b1);
    check("run_count_56", cnt, 56);
    check("sat_count_held", cnt_s, 15);
    run_sw = 1'b0;
    cycles(3);
    ticks(4, 1'b1);
    check("run_off_mode", mode, 0);
    check("run_off_count", cnt, 60);

    // Single step, twice.
    do_reset();
    check("reset2_count", cnt, 0);
    press_step(1'b1);
    check("step1_mode", mode, 0);
    check("step1_count", cnt, 1);
    press_step(1'b1);
    check("step2_count", cnt, 2);

    // Bounce rejection: Step toggles every Tick.
    for (int i = 0; i < 10; i++) begin
      step_btn = ~step_btn;
      do_tick(1'b0, 1'b0);
    end
    check("bounce_mode", mode, 0);
    check("bounce_count", cnt, 2);

    // Halt coincident with Tick in RUN, then acknowledge.
    run_sw = 1'b1;
    cycles(3);
    ticks(4, 1'b0);
    do_tick(1'b1, 1'b0);
    do_tick(1'b0, 1'b1);
    check("halt_mode", mode, 3);
    check("halt_flag", halted, 1);
    check("halt_count", cnt, 3);
    press_step(1'b0);
    check("halt_run_on_mode", mode, 3);
    run_sw = 1'b0;
    cycles(3);
    ticks(4, 1'b0);
    check("halt_run_off_mode", mode, 3);
    press_step(1'b0);
    check("halt_ack_mode", mode, 0);
    check("halt_ack_flag", halted, 0);
    check("halt_ack_count", cnt, 3);

    // Reset one cycle after entering STEP, before any Tick.
    do_reset();
    step_btn = 1'b1;
    cycles(3);
    ticks(3, 1'b0);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    cycles(2);
    check("step_entered", mode, 2);
    rst = 1'b1;
    step_btn = 1'b0;
    cycles(1);
    check("midstep_mode", mode, 0);
    check("midstep_cpu_en", cpu_en, 0);
    check("midstep_halted", halted, 0);
    check("midstep_count", cnt, 0);
    check("midstep_sat_count", cnt_s, 0);
    cycles(2);
    rst = 1'b0;
    ticks(6, 1'b0);
    check("post_reset_mode", mode, 0);
    check("post_reset_count", cnt, 0);

    cycles(2);
    check("pending_expected", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step controller for the RISC CPU, fed by the clock divider's one-cycle enable pulse (`Tick`). It debounces the board's Run switch and Step button against `Tick` and gates `Tick` into a single-cycle CPU clock-enable (`CpuEn`). It supports free-run, single-step and halt-on-request modes, and keeps a saturating count of issued CPU cycles for the display.

## Interface
- `DebounceTicks`, default 4: consecutive `Tick` samples required before a debounced input changes (≥1).
- `CycleCntW`, default 16: width of `CycleCount`.
- Reset `Rst`, synchronous, active-high; clock `Clkin`.
- `Clkin` in 1: system clock (100 MHz board clock).
- `Rst` in 1: synchronous active-high reset.
- `Tick` in 1: one-cycle enable pulse from the clock divider.
- `RunSw` in 1: raw Run switch, asynchronous.
- `StepBtn` in 1: raw Step pushbutton, asynchronous.
- `HaltReq` in 1: CPU halt request (HALT opcode), synchronous to `Clkin`.
- `CpuEn` out 1: one-cycle CPU clock-enable.
- `Mode` out 2: current state encoding.
- `Halted` out 1: high while in HALT.
- `CycleCount` out `CycleCntW`: number of `CpuEn` pulses issued, saturating.

## Operation
- Reset values: `CpuEn`=0, `Mode`=IDLE, `Halted`=0, `CycleCount`=0, both debounced values=0, debounce counters=0, synchronizers=0.
- `RunSw` and `StepBtn` each pass through a 2-flop synchronizer, then a debouncer.
- Debouncer behaviour:
  - The debouncer acts only on `Tick` cycles.
  - If the sample equals the debounced value, its counter clears.
  - Otherwise the counter increments. On the `DebounceTicks`-th consecutive differing sample, the debounced value flips and the counter clears.
  - Between ticks, all debouncer state holds.
- `StepPulse`: one-cycle pulse on the rising edge of debounced Step. Falling edges produce nothing.
- States: IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALT=2'b11.
- IDLE:
  - `RunDb`=1 → RUN.
  - Otherwise `StepPulse` → STEP.
  - `HaltReq` is ignored.
- RUN:
  - `HaltReq` → HALT, with no `CpuEn` even if `Tick` is present.
  - Otherwise `RunDb`=0 → IDLE, with no `CpuEn`.
  - Otherwise `Tick` → `CpuEn` pulse.
  - `StepPulse` is ignored.
- STEP:
  - `HaltReq` → HALT.
  - Otherwise the first `Tick` → one `CpuEn` pulse, then IDLE.
  - Further `StepPulse` events are ignored.
- HALT:
  - `CpuEn` stays 0.
  - Exit to IDLE only on `StepPulse` while `RunDb`=0 (acknowledge).
  - `RunDb`=1 keeps the block in HALT.
- Priority within a cycle: `Rst` > `HaltReq` > `RunDb` low > `Tick`.
- `CycleCount` increments by 1 on every cycle where `CpuEn`=1. It holds at 2^`CycleCntW`−1 with no wrap.
- Reset mid-step: return to IDLE with no pending `CpuEn`.

## Timing
- `CpuEn`, `Mode`, `Halted` and `CycleCount` are registered outputs.
- `Tick` sampled high in cycle n while in RUN/STEP → `CpuEn`=1 in cycle n+1, for exactly one cycle.
- `CycleCount` updates in the cycle after `CpuEn`.
- Raw input to debounced value: 2 cycles of sync, then `DebounceTicks` ticks; the value flips in the cycle after the qualifying `Tick`.
- `StepPulse` rises in the cycle after the debounced Step rises.
- State transitions are visible on `Mode` one cycle after the deciding inputs.
- `HaltReq` coincident with `Tick` in RUN: `CpuEn` stays 0 and `Mode`=HALT next cycle.
- At most one `CpuEn` per `Tick`. `CpuEn` is never asserted in two consecutive cycles unless `Tick` is.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - the state encodings (IDLE/RUN/STEP/HALT) as a typedef'd 2-bit enum;
  - the `Mode` width constant.
- Sub-module `btn_debounce`, instantiated twice (Run, Step):
  - contains synchronizer, debounce counter, registered debounced output and rising-edge pulse;
  - parameter `DebounceTicks`; ports `Clkin`, `Rst`, `Tick`, raw in, debounced out, rise out.
- The top level holds the FSM, the `CpuEn` register and the saturating counter.

## Test plan
All scenarios use `Tick` every 10 cycles and `DebounceTicks`=4.
- Run free-run:
  - `RunSw`=1 held for 60 ticks → `Mode`=01 after debounce.
  - One `CpuEn` per subsequent `Tick`, each 1 cycle after `Tick`.
  - `CycleCount` equals the number of pulses.
- Single step:
  - `RunSw`=0; press `StepBtn` for 6 ticks, release → exactly one `CpuEn`, `Mode` returns to 00, `CycleCount`=1.
  - A second press → `CycleCount`=2.
- Bounce rejection: `StepBtn` toggling each `Tick` for 10 ticks → no `StepPulse`, `CpuEn` never asserted, `Mode` stays 00.
- Halt:
  - In RUN, assert `HaltReq` on the same cycle as `Tick` → no `CpuEn`, `Mode`=11, `Halted`=1.
  - Step press with `RunSw`=1 → stays HALT.
  - Set `RunSw`=0, then step press → `Mode`=00.
- Saturation: `CycleCntW`=4 in free-run for 20 ticks → `CycleCount` stops at 15.
- Reset mid-step: `Rst` asserted one cycle after entering STEP, before `Tick` → no `CpuEn`, all outputs return to reset values.
